io_input_port: RTL
==================

# io_input_port

Memory-mapped input peripheral for the single-cycle MIPS computer: the read-side counterpart to the LED/seven-segment output ports. It synchronizes the board switches, debounces the push-buttons, records button-press events in sticky flags, and presents all of this to the CPU data bus as readable registers. It also raises a level interrupt for unmasked pending presses. It sits beside data memory inside the computer and is selected by address decode.

## Interface
Parameters:
- BASE_ADDR, 32'hFFFF_FF00: base of the 256-byte window; only addr[31:8] is compared.
- DEBOUNCE_CYCLES, 16'd50000: cycles a raw key level must stay stable before it is accepted; legal range 2..65535.

Ports:
- clock, input, 1: the single clock; every register changes on its rising edge.
- resetn, input, 1: asynchronous reset, active-low.
- SW, input, 10: raw slide switches, asynchronous to clock.
- KEY, input, 4: raw push-buttons, asynchronous to clock; 0 = pressed.
- addr, input, 32: CPU byte address.
- rd, input, 1: read strobe.
- wr, input, 1: write strobe.
- wdata, input, 32: write data.
- rdata, output, 32: registered read data.
- irq, output, 1: `|(event & mask)`, registered.

## Operation
- sel = (addr[31:8] == BASE_ADDR[31:8]). Register index = addr[3:2]; addr[7:4] are ignored, so the four registers alias through the window.
- Register map. Unused bits read 0.
  - 0x0 SW_VAL, read-only: [9:0] = synchronized SW.
  - 0x4 KEY_VAL, read-only: [3:0] = debounced key state, 1 = pressed.
  - 0x8 KEY_EVT, read / write-1-to-clear: [3:0] sticky press flags.
  - 0xC KEY_MASK, read/write: [3:0] interrupt enables.
- Synchronizers: two flip-flop stages per bit for both SW and KEY.
- Debounce is per key. A 16-bit counter cnt[i] and a stable flag db[i] (pressed = 1):
  - While the synchronized value differs from db[i]: cnt[i] increments.
  - When cnt[i] == DEBOUNCE_CYCLES-1 and the value still differs: db[i] toggles and cnt[i] returns to 0.
  - When the synchronized value equals db[i]: cnt[i] returns to 0. A glitch therefore restarts the count.
- Events:
  - A rising edge of db[i] sets event[i] in the same cycle that db[i] becomes 1.
  - A falling edge of db[i] does not set event[i].
- Writes (wr & sel):
  - Index 2: event[i] is cleared where wdata[i] = 1.
  - Index 3: mask <= wdata[3:0].
  - Indices 0 and 1: writes are ignored.
- Simultaneous set and W1C on the same bit in the same cycle: the set wins, and event[i] stays 1.
- rd and wr asserted together: the read returns the pre-write value; the write applies as normal.
- Reads: when rd & sel, rdata <= the selected register; otherwise rdata <= 0. rdata is zero whenever the block is not read.
- Reads have no side effects.

## Timing
- Reset (resetn = 0, asynchronous) sets:
  - KEY synchronizer stages = 1 (released); SW synchronizer stages = 0.
  - db = 0, cnt = 0, event = 0, mask = 0.
  - rdata = 0, irq = 0.
- Reset in the middle of a debounce count discards the count, and no event is produced.
- Read latency: rdata is valid one clock after the edge that samples rd & sel.
- SW latency: a change on SW at edge t appears in SW_VAL at t+2, and is readable on rdata at t+3 at the earliest.
- KEY latency: a stable press that starts before edge t gives:
  - synchronized value at t+2;
  - db and event = 1 at t+2+DEBOUNCE_CYCLES;
  - irq (if the mask bit is set) at t+3+DEBOUNCE_CYCLES.
- irq is registered from the event and mask values of the previous cycle. After a W1C of the last pending bit, irq falls one cycle later.
- Counter arithmetic is 16-bit unsigned. It cannot wrap, because it resets at DEBOUNCE_CYCLES-1.

## Test plan
Benches run with DEBOUNCE_CYCLES = 4.
- Reset values: hold resetn = 0 with KEY = 4'hF and SW = 10'h3FF. Required: rdata = 0 and irq = 0. After release, the first read of 0xC returns 0, and a read of 0x0 returns 32'h3FF by the third cycle.
- Clean press: drive KEY[2] = 0 with mask = 4'h4. Required: KEY_VAL = 4'h4 and KEY_EVT = 4'h4 six cycles later; irq = 1 on the next cycle.
- Bounce rejection: toggle KEY[0] every 2 cycles for 20 cycles, then return it to 1. Required: KEY_VAL and KEY_EVT stay 0.
- W1C and set-priority:
  - With KEY_EVT = 4'h5, write 32'h1 to 0x8. Required: a read returns 4'h4.
  - Clear bit 2 in the same cycle that a new press of KEY[2] becomes stable. Required: the bit stays 1.
- Decode and aliasing:
  - Read BASE_ADDR+0x14. Required: returns the KEY_VAL contents.
  - Read 32'h0000_0004. Required: rdata = 0.
  - Write to 0x0. Required: SW_VAL is unchanged.
- Reset mid-count: assert resetn after 2 cycles of a stable KEY[1] press, then release it while the key is still held. Required: event[1] sets exactly DEBOUNCE_CYCLES + 2 cycles after release, not earlier.

Source files
------------

// File: rtl/io_input_port_if.sv
// io_input_port_if: CPU data-bus view of the memory-mapped input port
interface io_input_port_if;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    modport master (output addr, rd, wr, wdata, input rdata, irq);
    modport slave (input addr, rd, wr, wdata, output rdata, irq);
endinterface

// File: rtl/io_input_port.sv
// io_input_port: synchronized switches, debounced keys, sticky press events and irq on the CPU bus
module io_input_port #(
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FF00,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input logic            clock,
    input logic            resetn,
    input logic [9:0]      SW,
    input logic [3:0]      KEY,
    io_input_port_if.slave bus
);
    logic [9:0]  sw_meta, sw_sync;
    logic [3:0]  key_meta, key_sync;
    logic [15:0] cnt [4];
    logic [3:0]  db, evt, mask;
    logic [3:0]  pressed, differ, done, rise, clr;
    logic        sel, unused_bits;
    logic [1:0]  idx;
    logic [31:0] rd_val;

    assign sel         = bus.addr[31:8] == BASE_ADDR[31:8];
    assign idx         = bus.addr[3:2];
    assign pressed     = ~key_sync;
    assign differ      = pressed ^ db;
    assign unused_bits = ^{bus.addr[7:4], bus.addr[1:0], bus.wdata[31:4]};

    // terminal count per key, rising edges of the debounced level, W1C bits and the read mux
    always_comb begin
        done = 4'h0;
        for (int i = 0; i < 4; i++) done[i] = differ[i] && cnt[i] == DEBOUNCE_CYCLES - 16'd1;
        rise   = done & ~db;
        clr    = (bus.wr && sel && idx == 2'd2) ? bus.wdata[3:0] : 4'h0;
        rd_val = idx == 2'd0 ? {22'h0, sw_sync} :
                 idx == 2'd1 ? {28'h0, db} :
                 idx == 2'd2 ? {28'h0, evt} : {28'h0, mask};
    end

    // two-stage synchronizers; keys idle high (released)
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
        end else begin
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
            key_meta <= KEY;
            key_sync <= key_meta;
        end
    end

    // debounce: count while the level disagrees, flip the stable level at the terminal count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 4; i++) cnt[i] <= 16'h0;
            db <= 4'h0;
        end else begin
            for (int i = 0; i < 4; i++) cnt[i] <= (differ[i] && !done[i]) ? cnt[i] + 16'd1 : 16'h0;
            db <= db ^ done;
        end
    end

    // sticky events (a new press beats a same-cycle clear), mask, registered read data and irq
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            evt       <= 4'h0;
            mask      <= 4'h0;
            bus.rdata <= 32'h0;
            bus.irq   <= 1'b0;
        end else begin
            evt <= (evt & ~clr) | rise;
            if (bus.wr && sel && idx == 2'd3) mask <= bus.wdata[3:0];
            bus.rdata <= (bus.rd && sel) ? rd_val : 32'h0;
            bus.irq   <= |(evt & mask);
        end
    end
endmodule
